// File: rtl/tick_speed_pkg.sv
// tick_speed_pkg: shared period constants, speed codes and decoder FSM states
package tick_speed_pkg;
    localparam int PER_S0 = 1;
    localparam int PER_S1 = 2500001;
    localparam int PER_S2 = 12500000;
    localparam int PER_S3 = 6750000;
    typedef enum logic [1:0] {S0, S1, S2, S3} speed_e;
    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_e;
endpackage

// File: rtl/tick_period_counter.sv
// tick_period_counter: saturating cycle counter, reloaded to 1 by each tick
module tick_period_counter #(
    parameter int W = 26,
    parameter int MAX_PER = 50000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         tick,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    localparam logic [W-1:0] MAXV = W'(MAX_PER);
    always_ff @(posedge clock) begin
        if (reset) cnt <= '0;
        else if (tick) cnt <= W'(1);
        else if (en && cnt != MAXV) cnt <= cnt + W'(1);
    end
    assign at_max = cnt == MAXV;
endmodule

// File: rtl/tick_speed_decoder.sv
// tick_speed_decoder: measures tick-to-tick period and decodes it to a speed code.
// TICK_SPEED_JITTER_EN adds a jitter output (max period deviation while locked).
module tick_speed_decoder
    import tick_speed_pkg::*;
#(
    parameter int W = 26,
    parameter int TOL = 2,
    parameter int MAX_PER = 50000000,
    parameter int PER1 = PER_S1,
    parameter int PER2 = PER_S2,
    parameter int PER3 = PER_S3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    output logic [W-1:0] period,
    output logic [1:0]   speed,
    output logic         match,
    output logic         valid,
    output logic         locked,
`ifdef TICK_SPEED_JITTER_EN
    output logic [W-1:0] jitter,
`endif
    output logic         timeout
);
    localparam logic [W:0] TOLW = (W+1)'(TOL);
    state_e state, state_n;
    logic [W-1:0] cnt, period_n;
    logic [1:0] speed_n;
    logic at_max, hit0, hit1, hit2, hit3, hit, same;
    logic match_n, valid_n, locked_n, timeout_n;
    speed_e code;

    function automatic logic near(input logic [W-1:0] p, input int r);
        logic [W:0] pe, re;
        pe = {1'b0, p};
        re = {1'b0, W'(r)};
        return (pe + TOLW >= re) && (pe <= re + TOLW);
    endfunction

    tick_period_counter #(.W(W), .MAX_PER(MAX_PER)) u_cnt (
        .clock(clock), .reset(reset), .en(state != IDLE), .tick(tick),
        .cnt(cnt), .at_max(at_max)
    );

    // S0 is an exact match; the others accept +/-TOL, checked S1, S3, S2
    assign hit0 = cnt == W'(PER_S0);
    assign hit1 = near(cnt, PER1);
    assign hit3 = near(cnt, PER3);
    assign hit2 = near(cnt, PER2);
    assign hit  = hit0 | hit1 | hit2 | hit3;
    assign code = hit0 ? S0 : hit1 ? S1 : hit3 ? S3 : S2;
    assign same = hit && match && code == speed;

    always_comb begin
        state_n   = state;
        period_n  = period;
        speed_n   = speed;
        match_n   = match;
        valid_n   = 1'b0;
        locked_n  = locked;
        timeout_n = timeout;
        if (tick) begin
            timeout_n = 1'b0;
            if (state == IDLE) state_n = ARMED;
            else begin
                period_n = cnt;
                match_n  = hit;
                speed_n  = hit ? code : speed;
                valid_n  = 1'b1;
                state_n  = (state != ARMED && same) ? LOCKED : TRACK;
                locked_n = state_n == LOCKED;
            end
        end else if (state != IDLE && at_max) begin
            timeout_n = 1'b1;
            locked_n  = 1'b0;
            state_n   = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            period  <= '0;
            speed   <= '0;
            match   <= 1'b0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            period  <= period_n;
            speed   <= speed_n;
            match   <= match_n;
            valid   <= valid_n;
            locked  <= locked_n;
            timeout <= timeout_n;
        end
    end

`ifdef TICK_SPEED_JITTER_EN
    logic [W-1:0] prev, jit, diff;
    assign diff = cnt >= prev ? cnt - prev : prev - cnt;
    // the entering period's deviation seeds the maximum on every lock entry
    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= '0;
            jit  <= '0;
        end else if (tick && state != IDLE) begin
            prev <= cnt;
            if (state_n == LOCKED) jit <= (state != LOCKED || diff > jit) ? diff : jit;
        end
    end
    assign jitter = jit;
`endif
endmodule

// File: tb/tb_tick_speed_decoder.sv
// tb_tick_speed_decoder: directed checks on a scaled-down decoder configuration
module tb_tick_speed_decoder;
    localparam int W = 12, TOL = 2, MAX_PER = 600, P1 = 101, P2 = 500, P3 = 270;
    logic clock = 0, reset = 1, tick = 0;
    logic [W-1:0] period;
    logic [1:0] speed;
    logic match, valid, locked, timeout;
`ifdef TICK_SPEED_JITTER_EN
    logic [W-1:0] jitter;
`endif
    int checks = 0, failures = 0;

    tick_speed_decoder #(.W(W), .TOL(TOL), .MAX_PER(MAX_PER), .PER1(P1), .PER2(P2), .PER3(P3)) dut (
        .clock(clock), .reset(reset), .tick(tick), .period(period), .speed(speed),
        .match(match), .valid(valid), .locked(locked),
`ifdef TICK_SPEED_JITTER_EN
        .jitter(jitter),
`endif
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1; tick = 0;
        cyc(2);
        reset = 0;
    endtask

    // tick edges n cycles after the previous one; returns just after the sampling edge
    task automatic tick_gap(input int n);
        tick = 0;
        cyc(n - 1);
        tick = 1;
        cyc(1);
        tick = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick = 1;
        cyc(2);
        checks++;
        if ({period, speed, match, valid, locked, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {period, speed, match, valid, locked, timeout});
        end
        reset = 0; tick = 0;
    endtask

    task automatic test_held_tick();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick = 1;
            cyc(1);
            checks++;
            if ({valid, locked} !== {i >= 2, i >= 3}) begin
                failures++;
                $display("FAIL held_vl[%0d] got=%b exp=%b", i, {valid, locked}, {i >= 2, i >= 3});
            end
            if (i >= 2) begin
                checks++;
                if ({period, speed, match} !== {12'd1, 2'd0, 1'b1}) begin
                    failures++;
                    $display("FAIL held_psm[%0d] got=%0d/%0d/%0b exp=1/0/1", i, period, speed, match);
                end
            end
        end
        tick = 0;
        cyc(1);
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL held_valid_drop got=%b exp=0", valid); end
    endtask

    task automatic test_s1_lock();
        do_reset();
        tick_gap(1);
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL s1_arm_valid got=%b exp=0", valid); end
        tick_gap(P1);
        checks++;
        if ({valid, period, speed, match, locked} !== {1'b1, 12'd101, 2'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL s1_first got v%b p%0d s%0d m%b l%b exp v1 p101 s1 m1 l0", valid, period, speed, match, locked);
        end
        cyc(1);
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL s1_strobe got=%b exp=0", valid); end
        tick_gap(P1 - 1);
        checks++;
        if ({valid, period, speed, locked} !== {1'b1, 12'd101, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL s1_lock got v%b p%0d s%0d l%b exp v1 p101 s1 l1", valid, period, speed, locked);
        end
    endtask

    task automatic test_tolerance();
        do_reset();
        tick_gap(1);
        tick_gap(P3 - 1);
        checks++;
        if ({speed, match, locked} !== {2'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL tol_269 got s%0d m%b l%b exp s3 m1 l0", speed, match, locked);
        end
        tick_gap(P3 + 1);
        checks++;
        if ({period, speed, locked} !== {12'd271, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL tol_271 got p%0d s%0d l%b exp p271 s3 l1", period, speed, locked);
        end
`ifdef TICK_SPEED_JITTER_EN
        checks++;
        if (jitter !== 12'd2) begin failures++; $display("FAIL tol_jitter got=%0d exp=2", jitter); end
`endif
        tick_gap(P3 + TOL);
        checks++;
        if ({match, locked} !== 2'b11) begin failures++; $display("FAIL tol_edge got m%b l%b exp m1 l1", match, locked); end
        tick_gap(P3 + TOL + 1);
        checks++;
        if ({valid, match, speed, locked} !== {1'b1, 1'b0, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL tol_out got v%b m%b s%0d l%b exp v1 m0 s3 l0", valid, match, speed, locked);
        end
    endtask

    task automatic test_relock();
        do_reset();
        tick_gap(1);
        tick_gap(P1);
        tick_gap(P1);
        tick_gap(P2);
        checks++;
        if ({speed, match, locked} !== {2'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL relock_change got s%0d m%b l%b exp s2 m1 l0", speed, match, locked);
        end
        tick_gap(P2);
        checks++;
        if ({period, speed, locked} !== {12'd500, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL relock_s2 got p%0d s%0d l%b exp p500 s2 l1", period, speed, locked);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick_gap(1);
        tick_gap(P1);
        tick_gap(P1);
        cyc(MAX_PER - 1);
        checks++;
        if ({timeout, locked} !== 2'b01) begin failures++; $display("FAIL to_early got t%b l%b exp t0 l1", timeout, locked); end
        cyc(1);
        checks++;
        if ({timeout, locked, period, speed} !== {1'b1, 1'b0, 12'd101, 2'd1}) begin
            failures++;
            $display("FAIL to_fire got t%b l%b p%0d s%0d exp t1 l0 p101 s1", timeout, locked, period, speed);
        end
        tick_gap(5);
        checks++;
        if ({timeout, valid, period} !== {1'b0, 1'b0, 12'd101}) begin
            failures++;
            $display("FAIL to_clear got t%b v%b p%0d exp t0 v0 p101", timeout, valid, period);
        end
        tick_gap(P1);
        checks++;
        if ({valid, period, locked} !== {1'b1, 12'd101, 1'b0}) begin
            failures++;
            $display("FAIL to_rearm got v%b p%0d l%b exp v1 p101 l0", valid, period, locked);
        end
        tick_gap(MAX_PER);
        checks++;
        if ({timeout, valid, period, match} !== {1'b0, 1'b1, 12'd600, 1'b0}) begin
            failures++;
            $display("FAIL to_tick_wins got t%b v%b p%0d m%b exp t0 v1 p600 m0", timeout, valid, period, match);
        end
    endtask

    task automatic test_nomatch_reset();
        do_reset();
        tick_gap(1);
        tick_gap(P1);
        tick_gap(350);
        checks++;
        if ({valid, match, speed, period} !== {1'b1, 1'b0, 2'd1, 12'd350}) begin
            failures++;
            $display("FAIL nm_hold got v%b m%b s%0d p%0d exp v1 m0 s1 p350", valid, match, speed, period);
        end
        reset = 1;
        cyc(1);
        checks++;
        if ({period, speed, match, valid, locked, timeout} !== '0) begin
            failures++;
            $display("FAIL nm_reset got=%h exp=0", {period, speed, match, valid, locked, timeout});
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_held_tick();
        test_s1_lock();
        test_tolerance();
        test_relock();
        test_timeout();
        test_nomatch_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
